// File: rtl/vector_response_checker.sv
// Exhaustive-vector response checker: walks every input vector in ascending order,
// samples the DUT after a settle time and scores it against a golden truth table.
module vector_response_checker #(
   parameter int N_IN   = 2,
   parameter int OUT_W  = 1,
   parameter int SETTLE = 1
) (
   input  logic                        CK,
   input  logic                        reset,
   input  logic                        start,
   input  logic [(2**N_IN)*OUT_W-1:0]  golden,
   input  logic [OUT_W-1:0]            dut_out,
   output logic [N_IN-1:0]             vec_out,
   output logic                        vec_valid,
   output logic                        sample_strobe,
   output logic                        busy,
   output logic                        done,
   output logic                        pass,
   output logic [N_IN:0]               err_count,
   output logic [N_IN-1:0]             first_err_idx
);

   localparam int NV = 2**N_IN;
   localparam int GW = NV*OUT_W;
   localparam int CW = (SETTLE > 0) ? $clog2(SETTLE+1) : 1;

   localparam logic [CW-1:0]   SETTLE_LD = CW'(SETTLE);
   localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
   localparam logic [N_IN-1:0] LAST_VEC  = N_IN'(NV-1);
   localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
   localparam logic [N_IN:0]   ERR_ONE   = (N_IN+1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t            state_q,  state_d;
   logic [N_IN-1:0]   vec_q,    vec_d;
   logic [CW-1:0]     cnt_q,    cnt_d;
   logic [GW-1:0]     golden_q, golden_d;
   logic [N_IN:0]     err_q,    err_d;
   logic [N_IN-1:0]   first_q,  first_d;
   logic              pass_q,   pass_d;

   logic [OUT_W-1:0]  exp_out;
   logic              mismatch;

   always_comb begin
      exp_out = golden_q[int'(vec_q)*OUT_W +: OUT_W];
      // Defaulting to mismatch means an X/Z response never silently passes.
      mismatch = 1'b1;
      if (dut_out == exp_out) mismatch = 1'b0;
   end

   always_comb begin
      state_d       = state_q;
      vec_d         = vec_q;
      cnt_d         = cnt_q;
      golden_d      = golden_q;
      err_d         = err_q;
      first_d       = first_q;
      pass_d        = pass_q;
      sample_strobe = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               golden_d = golden;
               vec_d    = '0;
               cnt_d    = SETTLE_LD;
               err_d    = '0;
               first_d  = '0;
               pass_d   = 1'b0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               sample_strobe = 1'b1;
               if (mismatch) begin
                  err_d = err_q + ERR_ONE;
                  if (err_q == '0) first_d = vec_q;
               end
               if (vec_q != LAST_VEC) begin
                  vec_d = vec_q + VEC_ONE;
                  cnt_d = SETTLE_LD;
               end else begin
                  state_d = S_DONE;
                  pass_d  = (err_d == '0);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CK or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         vec_q    <= '0;
         cnt_q    <= '0;
         golden_q <= '0;
         err_q    <= '0;
         first_q  <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         cnt_q    <= cnt_d;
         golden_q <= golden_d;
         err_q    <= err_d;
         first_q  <= first_d;
         pass_q   <= pass_d;
      end
   end

   assign vec_out       = vec_q;
   assign vec_valid     = (state_q == S_RUN);
   assign busy          = (state_q == S_RUN);
   assign done          = (state_q == S_DONE);
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign first_err_idx = first_q;

endmodule

// File: tb/tb_vector_response_checker.sv
// Bench for vector_response_checker: two instances (SETTLE=1 and SETTLE=0) scored
// against a queue of expected vectors and run results built from a truth-table model.
module tb_vector_response_checker;

   localparam int N_IN  = 2;
   localparam int OUT_W = 1;
   localparam int NV    = 4;

   logic CK = 1'b0;
   logic reset = 1'b0;
   logic start = 1'b0;
   logic [NV*OUT_W-1:0] golden = '0;
   int sel = 1;
   int mode = 0;

   logic [N_IN-1:0] vec_out_s1, vec_out_s0, first_s1, first_s0;
   logic [N_IN:0]   err_s1, err_s0;
   logic            valid_s1, valid_s0, strobe_s1, strobe_s0, busy_s1, busy_s0;
   logic            done_s1, done_s0, pass_s1, pass_s0;
   logic [OUT_W-1:0] dut_out_s1, dut_out_s0;
   logic            start_s1, start_s0;

   logic [N_IN-1:0] m_vec, m_first;
   logic [N_IN:0]   m_err;
   logic            m_valid, m_strobe, m_busy, m_done, m_pass;

   int checks = 0;
   int errors = 0;

   typedef struct { logic [N_IN-1:0] vec; logic strobe; } vec_exp_t;
   typedef struct { logic [N_IN:0] err; logic [N_IN-1:0] first; logic pass; } res_exp_t;
   vec_exp_t vec_sb[$];
   res_exp_t res_sb[$];

   always #5 CK = ~CK;

   // Reference DUT behaviours: 0 AND, 1 AND with vector 2 stuck at 1, 2 NAND, 3 XOR.
   function automatic logic resp_f(input int m, input logic [N_IN-1:0] v);
      case (m)
         0: resp_f = &v;
         1: resp_f = (v == 2'd2) ? 1'b1 : &v;
         2: resp_f = ~&v;
         default: resp_f = ^v;
      endcase
   endfunction

   assign dut_out_s1 = resp_f(mode, vec_out_s1);
   assign dut_out_s0 = resp_f(mode, vec_out_s0);
   assign start_s1   = start && (sel == 1);
   assign start_s0   = start && (sel == 0);

   vector_response_checker #(.N_IN(N_IN), .OUT_W(OUT_W), .SETTLE(1)) u_dut_s1 (
      .CK(CK), .reset(reset), .start(start_s1), .golden(golden), .dut_out(dut_out_s1),
      .vec_out(vec_out_s1), .vec_valid(valid_s1), .sample_strobe(strobe_s1),
      .busy(busy_s1), .done(done_s1), .pass(pass_s1),
      .err_count(err_s1), .first_err_idx(first_s1));

   vector_response_checker #(.N_IN(N_IN), .OUT_W(OUT_W), .SETTLE(0)) u_dut_s0 (
      .CK(CK), .reset(reset), .start(start_s0), .golden(golden), .dut_out(dut_out_s0),
      .vec_out(vec_out_s0), .vec_valid(valid_s0), .sample_strobe(strobe_s0),
      .busy(busy_s0), .done(done_s0), .pass(pass_s0),
      .err_count(err_s0), .first_err_idx(first_s0));

   always_comb begin
      if (sel == 1) begin
         m_vec = vec_out_s1; m_first = first_s1; m_err = err_s1; m_valid = valid_s1;
         m_strobe = strobe_s1; m_busy = busy_s1; m_done = done_s1; m_pass = pass_s1;
      end else begin
         m_vec = vec_out_s0; m_first = first_s0; m_err = err_s0; m_valid = valid_s0;
         m_strobe = strobe_s0; m_busy = busy_s0; m_done = done_s0; m_pass = pass_s0;
      end
   end

   // Full run on the selected instance; restart_at >= 0 pulses start mid-run.
   task automatic run_check(input string name, input int s, input logic [NV-1:0] g,
                            input int m, input int restart_at);
      int e;
      int cyc;
      int limit;
      logic [N_IN-1:0] f;
      logic [N_IN-1:0] v;
      vec_exp_t ve;
      res_exp_t re;
      sel = s; golden = g; mode = m;
      e = 0; f = '0;
      for (int i = 0; i < NV; i++) begin
         v = i[N_IN-1:0];
         if (resp_f(m, v) !== g[i]) begin
            if (e == 0) f = v;
            e++;
         end
         for (int k = 0; k <= s; k++) begin
            ve.vec = v; ve.strobe = (k == s);
            vec_sb.push_back(ve);
         end
      end
      re.err = e[N_IN:0]; re.first = f; re.pass = (e == 0);
      res_sb.push_back(re);

      start = 1'b1;
      @(posedge CK); #1;
      start = 1'b0;
      golden = ~g;
      checks++; if (m_busy !== 1'b1 || m_done !== 1'b0) begin errors++;
         $display("FAIL %s start busy/done got %b/%b want 1/0", name, m_busy, m_done); end
      checks++; if (m_err !== '0 || m_first !== '0) begin errors++;
         $display("FAIL %s start clear err/first got %0d/%0d want 0/0", name, m_err, m_first); end

      cyc = 0;
      limit = NV*(s+1) + 8;
      while (m_done !== 1'b1 && cyc < limit) begin
         if (vec_sb.size() > 0) begin
            ve = vec_sb.pop_front();
            checks++;
            if (m_vec !== ve.vec || m_strobe !== ve.strobe || m_valid !== 1'b1) begin
               errors++;
               $display("FAIL %s cyc%0d vec/strobe/valid got %0d/%b/%b want %0d/%b/1",
                        name, cyc, m_vec, m_strobe, m_valid, ve.vec, ve.strobe);
            end
         end
         start = (cyc == restart_at);
         @(posedge CK); #1;
         cyc++;
      end
      start = 1'b0;
      checks++; if (cyc != NV*(s+1)) begin errors++;
         $display("FAIL %s done latency got %0d want %0d", name, cyc, NV*(s+1)); end
      checks++; if (vec_sb.size() != 0) begin errors++;
         $display("FAIL %s unconsumed vectors got %0d want 0", name, vec_sb.size());
         vec_sb.delete(); end

      re = res_sb.pop_front();
      checks++; if (m_err !== re.err || m_first !== re.first || m_pass !== re.pass) begin
         errors++;
         $display("FAIL %s result err/first/pass got %0d/%0d/%b want %0d/%0d/%b",
                  name, m_err, m_first, m_pass, re.err, re.first, re.pass);
      end
      checks++; if (m_done !== 1'b1 || m_busy !== 1'b0 || m_valid !== 1'b0 || m_vec !== 2'd3) begin
         errors++;
         $display("FAIL %s done state done/busy/valid/vec got %b/%b/%b/%0d want 1/0/0/3",
                  name, m_done, m_busy, m_valid, m_vec);
      end
      $display("run %s: err=%0d first=%0d pass=%b cycles=%0d", name, m_err, m_first, m_pass, cyc);
   endtask

   task automatic test_reset();
      #1;
      checks++; if ({vec_out_s1, valid_s1, strobe_s1, busy_s1, done_s1, pass_s1, err_s1, first_s1} !== '0) begin
         errors++; $display("FAIL reset_s1 outputs got %b want 0",
            {vec_out_s1, valid_s1, strobe_s1, busy_s1, done_s1, pass_s1, err_s1, first_s1}); end
      checks++; if ({vec_out_s0, valid_s0, strobe_s0, busy_s0, done_s0, pass_s0, err_s0, first_s0} !== '0) begin
         errors++; $display("FAIL reset_s0 outputs got %b want 0",
            {vec_out_s0, valid_s0, strobe_s0, busy_s0, done_s0, pass_s0, err_s0, first_s0}); end
      @(posedge CK); #1;
      reset = 1'b1;
      @(posedge CK); #1;
      checks++; if (busy_s1 !== 1'b0 || done_s1 !== 1'b0) begin errors++;
         $display("FAIL idle busy/done got %b/%b want 0/0", busy_s1, done_s1); end
   endtask

   task automatic test_reset_midrun();
      sel = 1; golden = 4'b1000; mode = 0;
      start = 1'b1;
      @(posedge CK); #1;
      start = 1'b0;
      @(posedge CK); #1;
      @(posedge CK); #1;
      checks++; if (m_vec !== 2'd1 || m_strobe !== 1'b0) begin errors++;
         $display("FAIL midrun pre-reset vec/strobe got %0d/%b want 1/0", m_vec, m_strobe); end
      #2 reset = 1'b0;
      #1;
      checks++; if ({m_vec, m_valid, m_strobe, m_busy, m_done, m_pass, m_err, m_first} !== '0) begin
         errors++; $display("FAIL midrun async reset outputs got %b want 0",
            {m_vec, m_valid, m_strobe, m_busy, m_done, m_pass, m_err, m_first}); end
      @(posedge CK); #1;
      reset = 1'b1;
      run_check("after_reset", 1, 4'b1000, 0, -1);
   endtask

   task automatic test_back_to_back();
      run_check("restart_in_run", 1, 4'b1000, 1, 3);
      repeat (3) @(posedge CK);
      #1;
      checks++; if (m_done !== 1'b1 || m_vec !== 2'd3 || m_err !== 3'd1) begin errors++;
         $display("FAIL done hold done/vec/err got %b/%0d/%0d want 1/3/1", m_done, m_vec, m_err); end
      run_check("restart_from_done_xor", 1, 4'b0110, 3, -1);
   endtask

   initial begin
      test_reset();
      run_check("and_pass", 1, 4'b1000, 0, -1);
      run_check("single_error", 1, 4'b1000, 1, -1);
      run_check("all_wrong", 1, 4'b1000, 2, -1);
      run_check("settle0_pass", 0, 4'b1000, 0, -1);
      run_check("settle0_error", 0, 4'b1000, 1, -1);
      test_reset_midrun();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vector_response_checker.md
Name: vector_response_checker

Overview:
- Synthesizable response side of the exhaustive-vector bench flow. It generates every input vector of a small combinational or sequential DUT in ascending order (all zeros first, then up to all ones).
- After a programmable settle time it samples the DUT output for each vector and compares it against a golden truth table.
- It reports the mismatch count, the first failing vector and pass/done status, for on-chip trojan and regression checking alongside the file-dump benches.

Parameters:
- N_IN, 2, number of DUT input bits; the block runs 2^N_IN vectors.
- OUT_W, 1, DUT output width in bits.
- SETTLE, 1, extra cycles each vector is held before sampling (0 allowed).

Ports:
- CK  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a run; sampled in IDLE and DONE only.
- golden  input  (2^N_IN)*OUT_W  expected outputs; slice golden[i*OUT_W +: OUT_W] is the expected output for vector i; captured at start.
- dut_out  input  OUT_W  DUT response.
- vec_out  output  N_IN  applied vector = binary index i; vec_out[N_IN-1] is the MSB.
- vec_valid  output  1  high while a vector is being driven.
- sample_strobe  output  1  high in the cycle whose ending edge samples dut_out.
- busy  output  1  run in progress.
- done  output  1  run complete; held until the next start.
- pass  output  1  done and err_count==0.
- err_count  output  N_IN+1  number of mismatching vectors.
- first_err_idx  output  N_IN  index of the first mismatch; 0 if none.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (reset=0), applied immediately and at any point, including mid-run:
  - state=IDLE, vec_out=0, vec_valid=0, sample_strobe=0, busy=0, done=0, pass=0, err_count=0, first_err_idx=0;
  - golden capture register and settle counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE with start=1 at edge t0:
  - golden is latched, vec_out=0, settle counter=SETTLE, err_count=0, first_err_idx=0;
  - done=0, pass=0, busy=1, vec_valid=1; state goes to RUN.
- RUN, settle counter > 0: decrement; vec_out holds.
- RUN, settle counter == 0:
  - sample_strobe=1 combinationally that cycle; at the ending edge, dut_out is compared with the latched golden slice for vec_out.
  - On mismatch, err_count increments; if err_count was 0, first_err_idx=vec_out.
  - If vec_out != 2^N_IN-1: vec_out increments and the counter reloads to SETTLE.
  - Otherwise go to DONE: busy=0, vec_valid=0, done=1, pass = (final err_count==0). The pass value includes the final vector's comparison.
- Timing: each vector is held SETTLE+1 cycles. done rises at edge t0 + 2^N_IN*(SETTLE+1). Vector changes occur only at period boundaries.
- Comparison is exact across all OUT_W bits. Any differing bit marks that vector as a mismatch; err_count counts vectors, not bits. err_count never exceeds 2^N_IN, so no saturation is needed.
- start while in RUN is ignored; no restart and no effect on counters.
- In DONE, outputs hold; vec_out stays at 2^N_IN-1.
- start in DONE restarts at the next edge and clears the results, exactly as from IDLE.
- golden changes after start have no effect until the next start.
- dut_out is not sampled outside sample_strobe cycles. X on dut_out at the sample edge counts as a mismatch in simulation; the bench must avoid this.

Test Plan:
- N_IN=2, SETTLE=1, golden=4'b1000 (AND), dut_out = &vec_out. Pulse start -> vec_out 00,01,10,11, two cycles each; done=1 after 8 cycles; pass=1, err_count=0, first_err_idx=0.
- Same, but dut_out forced to 1 during vector 2 -> err_count=1, first_err_idx=2, pass=0.
- golden=4'b1000, dut_out = ~&vec_out (all vectors wrong) -> err_count=4, first_err_idx=0, pass=0.
- SETTLE=0 -> one cycle per vector; done rises 4 cycles after start; sample_strobe high in all 4 run cycles.
- Drop reset low during the vector-1 settle cycle -> all outputs return to 0 without waiting for CK. After release, start -> full clean run, pass=1.
- start pulsed again during RUN -> ignored, results unchanged. start in DONE -> done drops the next cycle and a new run with a new golden value completes correctly.
